// File: rtl/add_pkg.sv
// Shared types for the add/add-inverse pair.
package add_pkg;

  localparam int unsigned W_DEF = 32;

  typedef logic [W_DEF-1:0] word_t;

  typedef struct packed {
    word_t b;
    logic  borrow;
  } inv_res_t;

endpackage

// File: rtl/result_fifo.sv
// Small result FIFO with count-based full/empty and a registered head.
// The head is registered so that it keeps the last popped value when the FIFO drains,
// instead of exposing whatever stale slot the read pointer lands on.
module result_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  T              dout_q, dout_d;
  logic [PW-1:0] rptr_q, wptr_q, head_idx;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // Ignore push when full and pop when empty so callers cannot corrupt state.
  assign push_ok = push && (count_q != (PW+1)'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Next count and the value that will sit at the head after this edge.
  always_comb begin
    count_d  = count_q;
    dout_d   = dout_q;
    head_idx = pop_ok ? rptr_q + PW'(1) : rptr_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    // An entry being written this edge can only become head if it lands on head_idx.
    if (count_d != '0) begin
      dout_d = (push_ok && (head_idx == wptr_q)) ? din : mem_q[head_idx];
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage; only written on an accepted push, so idle inputs never enter.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/add_inverse.sv
// Recovers b = sum - a from an adder's output and one addend, flags a > sum,
// and queues the results behind a valid/ready FIFO.
module add_inverse
  import add_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  sum,
  input  logic [W-1:0]  a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  b,
  output logic          borrow,
  output logic [CW-1:0] underflow_cnt
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Same layout as inv_res_t, widened to the instance's W.
  typedef struct packed {
    logic [W-1:0] b;
    logic         borrow;
  } res_t;

  logic [CntW-1:0] count;
  logic            accept, pop;
  res_t            res_new, res_head;
  logic [CW-1:0]   ucnt_q;

  // Handshake decode from the registered count only; no path from out_ready to in_ready.
  assign in_ready  = (count != CntW'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Modular subtract and unsigned borrow detect.
  always_comb begin
    res_new.b      = sum - a;
    res_new.borrow = (a > sum);
  end

  result_fifo #(
    .T     (res_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (res_new),
    .dout  (res_head),
    .count (count)
  );

  // Saturating count of accepted pairs that borrowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (accept && res_new.borrow && (ucnt_q != '1)) begin
      ucnt_q <= ucnt_q + CW'(1);
    end
  end

  assign b             = res_head.b;
  assign borrow        = res_head.borrow;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_add_inverse.sv
// Directed bench for add_inverse: a queue model checked every cycle, plus literal checks.
module tb_add_inverse;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum_s = '0;
  logic [W-1:0] a_s = '0;

  // Registered adder feeding the round-trip test.
  logic         rt = 1'b0;
  logic [W-1:0] add_a = 32'd5;
  logic [W-1:0] add_b = '0;
  logic [W-1:0] add_q = '0;
  logic         add_v = 1'b0;
  logic         add_v_q = 1'b0;

  logic         in_valid_w;
  logic [W-1:0] sum_w, a_w;

  logic         in_ready, out_valid, borrow;
  logic [W-1:0] b;
  logic [15:0]  ucnt;
  logic         in_ready_s, out_valid_s, borrow_s;
  logic [W-1:0] b_s;
  logic [1:0]   ucnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    add_q   <= add_a + add_b;
    add_v_q <= add_v;
  end

  assign in_valid_w = rt ? add_v_q : in_valid;
  assign sum_w      = rt ? add_q : sum_s;
  assign a_w        = rt ? add_a : a_s;

  add_inverse #(.W(W), .DEPTH(DEPTH), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready), .sum(sum_w), .a(a_w),
    .out_valid(out_valid), .out_ready(out_ready), .b(b), .borrow(borrow),
    .underflow_cnt(ucnt)
  );

  add_inverse #(.W(W), .DEPTH(DEPTH), .CW(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_s), .sum(sum_w), .a(a_w),
    .out_valid(out_valid_s), .out_ready(out_ready), .b(b_s), .borrow(borrow_s),
    .underflow_cnt(ucnt_s)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: results queue, last popped value, two saturating counters.
  typedef struct packed {
    logic [W-1:0] b;
    logic         borrow;
  } res_t;

  res_t        mq[$];
  res_t        m_last = '0;
  int unsigned m_cnt16 = 0;
  int unsigned m_cnt2 = 0;
  bit          model_on = 1'b0;

  // At each negedge: compare DUT against model, then advance the model with the inputs
  // that the next posedge will sample.
  always @(negedge clk) begin
    res_t head;
    res_t r;
    bit   acc, pp;
    if (model_on) begin
      head = (mq.size() != 0) ? mq[0] : m_last;
      chk("in_ready", in_ready, mq.size() != DEPTH);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("b", b, head.b);
      chk("borrow", borrow, head.borrow);
      chk("underflow_cnt", ucnt, m_cnt16);
      chk("in_ready_cw2", in_ready_s, mq.size() != DEPTH);
      chk("out_valid_cw2", out_valid_s, mq.size() != 0);
      chk("b_cw2", b_s, head.b);
      chk("borrow_cw2", borrow_s, head.borrow);
      chk("underflow_cnt_cw2", ucnt_s, m_cnt2);
    end
    if (rst) begin
      mq.delete();
      m_last   = '0;
      m_cnt16  = 0;
      m_cnt2   = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      acc = in_valid_w && (mq.size() < DEPTH);
      pp  = out_ready && (mq.size() != 0);
      if (pp) m_last = mq.pop_front();
      if (acc) begin
        r.b      = sum_w - a_w;
        r.borrow = (a_w > sum_w);
        mq.push_back(r);
        if (r.borrow) begin
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    // Reset held two edges with in_valid high.
    rst = 1'b1; in_valid = 1'b1; sum_s = 32'd12; a_s = 32'd5;
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_ucnt", ucnt, 0);
    chk("t1_b", b, 0);

    // 12 - 5, one-cycle latency, popped immediately.
    sum_s = 32'd12; a_s = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("t2_b", b, 7);
    chk("t2_borrow", borrow, 0);
    chk("t2_out_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("t2_drained", out_valid, 0);
    chk("t2_b_hold", b, 7);

    // Borrow case then equal operands.
    sum_s = 32'd3; a_s = 32'd5; in_valid = 1'b1;
    step();
    chk("t3_b", b, 32'hFFFF_FFFE);
    chk("t3_borrow", borrow, 1);
    chk("t3_ucnt", ucnt, 1);
    sum_s = 32'd5; a_s = 32'd5;
    step();
    chk("t3_eq_b", b, 0);
    chk("t3_eq_borrow", borrow, 0);
    chk("t3_eq_ucnt", ucnt, 1);
    in_valid = 1'b0;
    sum_s = 32'hDEAD_BEEF; a_s = 32'hFFFF_FFFF;
    step(); step();
    chk("t3_idle_ucnt", ucnt, 1);

    // Fill with out_ready low, then drain in order.
    out_ready = 1'b0; a_s = 32'd5; in_valid = 1'b1;
    sum_s = 32'd10; step();
    sum_s = 32'd11; step();
    chk("t4_full", in_ready, 0);
    chk("t4_head", b, 5);
    sum_s = 32'd12; step(); step();
    chk("t4_stall_head", b, 5);
    chk("t4_stall_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("t4_pop1", b, 6);
    step();
    chk("t4_pop2", b, 7);
    sum_s = 32'd13;
    step();
    chk("t4_pop3", b, 8);
    in_valid = 1'b0;
    step();
    chk("t4_empty", out_valid, 0);
    chk("t4_hold", b, 8);

    // Round trip through a registered adder with a=5.
    rt = 1'b1; out_ready = 1'b1;
    for (int i = 0; i <= 21; i++) begin
      add_b = (i <= 20) ? W'(i) : '0;
      add_v = (i <= 20);
      step();
      if (i >= 1) begin
        chk("t5_rt_b", b, i - 1);
        chk("t5_rt_valid", out_valid, 1);
      end
    end
    add_v = 1'b0;
    step(); step();
    rt = 1'b0;
    step();

    // Saturation on the CW=2 instance, then reset with two entries queued.
    rst = 1'b1; step(); rst = 1'b0;
    sum_s = 32'd0; a_s = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_sat_cw2", ucnt_s, sat_exp[k]);
      chk("t6_cnt_cw16", ucnt, k + 1);
    end
    out_ready = 1'b0;
    step();
    chk("t6_full", in_ready, 0);
    chk("t6_valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_cnt", ucnt, 0);
    chk("t6_rst_cnt_cw2", ucnt_s, 0);
    chk("t6_rst_b", b, 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
